parity_serializer: RTL and testbench



---
 rtl/parity_serializer_if.sv | 39 +++
 rtl/parity_serializer.sv | 135 +++++++++++++
 tb/tb_parity_serializer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/parity_serializer_if.sv
// Word-parallel producer to serial-link handshake bundle for parity_serializer.
// The master side is the word producer; the slave side is the serializer.
interface parity_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             odd_sel;
   logic             in_valid;
   logic             in_ready;
   logic             ser_out;
   logic             ser_valid;
   logic             frame_start;
   logic             par_slot;
   logic             busy;

   modport master (
      output data_in,
      output odd_sel,
      output in_valid,
      input  in_ready,
      input  ser_out,
      input  ser_valid,
      input  frame_start,
      input  par_slot,
      input  busy
   );

   modport slave (
      input  data_in,
      input  odd_sel,
      input  in_valid,
      output in_ready,
      output ser_out,
      output ser_valid,
      output frame_start,
      output par_slot,
      output busy
   );
endinterface

// File: rtl/parity_serializer.sv
// Parity serializer: accepts a WIDTH-bit word over valid/ready, shifts it out
// LSB first on a single wire, then appends one even/odd parity bit.
// A frame is WIDTH data cycles followed by one parity cycle; a new word may be
// accepted during the parity cycle so back-to-back frames have no gap.
module parity_serializer #(
   parameter int WIDTH = 8
) (
   input logic               clk,
   input logic               rst_n,
   parity_serializer_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DATA = 2'd1;
   localparam logic [1:0] PAR  = 2'd2;

   // Counter value while the last data bit is on the wire.
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   // Parity bit to emit: running XOR of the data bits, inverted for odd mode.
   function automatic logic par_bit(input logic acc_v, input logic odd_v);
      return acc_v ^ odd_v;
   endfunction

   logic [1:0]       state,       state_d;
   logic [WIDTH-1:0] shift_reg,   shift_d;
   logic [CW-1:0]    cnt,         cnt_d;
   logic             acc,         acc_d;
   logic             odd_q,       odd_d;
   logic             ser_out_q,   ser_out_d;
   logic             ser_valid_q, ser_valid_d;
   logic             fstart_q,    fstart_d;
   logic             pslot_q,     pslot_d;
   logic             busy_q,      busy_d;
   logic             accept;

   // Ready is a pure state decode so the producer never sees a combinational
   // path from its own valid back to ready.
   assign bus.in_ready = (state == IDLE) || (state == PAR);
   assign accept       = bus.in_valid && bus.in_ready;

   assign bus.ser_out     = ser_out_q;
   assign bus.ser_valid   = ser_valid_q;
   assign bus.frame_start = fstart_q;
   assign bus.par_slot    = pslot_q;
   assign bus.busy        = busy_q;

   // Next-state and next-output decode; outputs are computed one cycle ahead
   // so that every serial-side output comes straight from a flop.
   always_comb begin
      state_d     = state;
      shift_d     = shift_reg;
      cnt_d       = cnt;
      acc_d       = acc;
      odd_d       = odd_q;
      ser_out_d   = 1'b0;
      ser_valid_d = 1'b0;
      fstart_d    = 1'b0;
      pslot_d     = 1'b0;

      case (state)
         IDLE: begin
            state_d = IDLE;
         end
         DATA: begin
            cnt_d   = cnt + 1'b1;
            shift_d = shift_reg >> 1;
            if (cnt == LAST_BIT) begin
               // All data bits have been sent; acc now covers the whole word.
               state_d     = PAR;
               ser_out_d   = par_bit(acc, odd_q);
               ser_valid_d = 1'b1;
               pslot_d     = 1'b1;
            end else begin
               // shift_reg[0] always holds the next bit still to be sent.
               ser_out_d   = shift_reg[0];
               ser_valid_d = 1'b1;
               acc_d       = acc ^ shift_reg[0];
            end
         end
         PAR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Accept can only happen in IDLE or PAR; it overrides the default
      // return to IDLE so a parity cycle chains directly into the next word.
      if (accept) begin
         state_d     = DATA;
         shift_d     = {1'b0, bus.data_in[WIDTH-1:1]};
         cnt_d       = '0;
         acc_d       = bus.data_in[0];
         odd_d       = bus.odd_sel;
         ser_out_d   = bus.data_in[0];
         ser_valid_d = 1'b1;
         fstart_d    = 1'b1;
         pslot_d     = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   // State, datapath and registered outputs; reset discards any partial frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         shift_reg   <= '0;
         cnt         <= '0;
         acc         <= 1'b0;
         odd_q       <= 1'b0;
         ser_out_q   <= 1'b0;
         ser_valid_q <= 1'b0;
         fstart_q    <= 1'b0;
         pslot_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_d;
         shift_reg   <= shift_d;
         cnt         <= cnt_d;
         acc         <= acc_d;
         odd_q       <= odd_d;
         ser_out_q   <= ser_out_d;
         ser_valid_q <= ser_valid_d;
         fstart_q    <= fstart_d;
         pslot_q     <= pslot_d;
         busy_q      <= busy_d;
      end
   end

endmodule

// File: tb/tb_parity_serializer.sv
// Directed bench for parity_serializer: WIDTH=8 and WIDTH=3 instances,
// table-driven frames plus back-to-back and mid-frame reset sequences.
module tb_parity_serializer;

   logic clk;
   logic rst_n;

   int n_chk;
   int n_fail;

   parity_serializer_if #(.WIDTH(8)) b8 ();
   parity_serializer_if #(.WIDTH(3)) b3 ();

   parity_serializer #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b8.slave)
   );

   parity_serializer #(.WIDTH(3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b3.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       odd;
      logic       par;
   } vec8_t;

   typedef struct {
      logic [2:0] data;
      logic       par;
   } vec3_t;

   vec8_t v8[10];
   vec3_t v3[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle8(input string tag);
      chk({tag, " ser_valid"},   32'(b8.ser_valid),   32'd0);
      chk({tag, " ser_out"},     32'(b8.ser_out),     32'd0);
      chk({tag, " frame_start"}, 32'(b8.frame_start), 32'd0);
      chk({tag, " par_slot"},    32'(b8.par_slot),    32'd0);
      chk({tag, " busy"},        32'(b8.busy),        32'd0);
      chk({tag, " in_ready"},    32'(b8.in_ready),    32'd1);
   endtask

   task automatic send8(input logic [7:0] d, input logic o, input logic p);
      b8.data_in  = d;
      b8.odd_sel  = o;
      b8.in_valid = 1'b1;
      tick();
      b8.in_valid = 1'b0;
      b8.data_in  = ~d;
      b8.odd_sel  = ~o;
      for (int i = 0; i < 8; i++) begin
         chk("w8 data ser_valid",   32'(b8.ser_valid),   32'd1);
         chk("w8 data bit",         32'(b8.ser_out),     32'(d[i]));
         chk("w8 data frame_start", 32'(b8.frame_start), 32'(i == 0));
         chk("w8 data par_slot",    32'(b8.par_slot),    32'd0);
         chk("w8 data busy",        32'(b8.busy),        32'd1);
         chk("w8 data in_ready",    32'(b8.in_ready),    32'd0);
         tick();
      end
      chk("w8 par ser_valid",   32'(b8.ser_valid),   32'd1);
      chk("w8 par par_slot",    32'(b8.par_slot),    32'd1);
      chk("w8 par bit",         32'(b8.ser_out),     32'(p));
      chk("w8 par frame_start", 32'(b8.frame_start), 32'd0);
      chk("w8 par busy",        32'(b8.busy),        32'd1);
      chk("w8 par in_ready",    32'(b8.in_ready),    32'd1);
      tick();
      chk_idle8("w8 after");
   endtask

   task automatic send3(input logic [2:0] d, input logic p);
      b3.data_in  = d;
      b3.odd_sel  = 1'b0;
      b3.in_valid = 1'b1;
      tick();
      b3.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         // Disturb the producer side mid-frame; the frame must not notice.
         b3.data_in = ~d;
         b3.odd_sel = 1'b1;
         chk("w3 data ser_valid",   32'(b3.ser_valid),   32'd1);
         chk("w3 data bit",         32'(b3.ser_out),     32'(d[i]));
         chk("w3 data frame_start", 32'(b3.frame_start), 32'(i == 0));
         chk("w3 data in_ready",    32'(b3.in_ready),    32'd0);
         tick();
      end
      b3.odd_sel = 1'b0;
      chk("w3 par par_slot", 32'(b3.par_slot), 32'd1);
      chk("w3 par bit",      32'(b3.ser_out),  32'(p));
      tick();
      chk("w3 after ser_valid", 32'(b3.ser_valid), 32'd0);
      chk("w3 after busy",      32'(b3.busy),      32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d0;
      logic [7:0] d1;
      logic       eb;

      n_chk  = 0;
      n_fail = 0;

      v8[0] = '{8'hA5, 1'b0, 1'b0};
      v8[1] = '{8'hA5, 1'b1, 1'b1};
      v8[2] = '{8'h07, 1'b1, 1'b0};
      v8[3] = '{8'h07, 1'b0, 1'b1};
      v8[4] = '{8'h01, 1'b0, 1'b1};
      v8[5] = '{8'hFF, 1'b0, 1'b0};
      v8[6] = '{8'h3C, 1'b0, 1'b0};
      v8[7] = '{8'h00, 1'b1, 1'b1};
      v8[8] = '{8'h80, 1'b0, 1'b1};
      v8[9] = '{8'hFE, 1'b1, 1'b0};

      v3[0] = '{3'd0, 1'b0};
      v3[1] = '{3'd1, 1'b1};
      v3[2] = '{3'd2, 1'b1};
      v3[3] = '{3'd3, 1'b0};
      v3[4] = '{3'd4, 1'b1};
      v3[5] = '{3'd5, 1'b0};
      v3[6] = '{3'd6, 1'b0};
      v3[7] = '{3'd7, 1'b1};

      rst_n       = 1'b1;
      b8.data_in  = '0;
      b8.odd_sel  = 1'b0;
      b8.in_valid = 1'b0;
      b3.data_in  = '0;
      b3.odd_sel  = 1'b0;
      b3.in_valid = 1'b0;

      // Reset asserted between clock edges must take effect at once.
      #12;
      rst_n = 1'b0;
      #1;
      chk_idle8("reset");
      chk("reset w3 in_ready",  32'(b3.in_ready),  32'd1);
      chk("reset w3 ser_valid", 32'(b3.ser_valid), 32'd0);
      #4;
      rst_n = 1'b1;

      // Table-driven single frames on the 8-bit instance.
      for (int k = 0; k < 10; k++) begin
         send8(v8[k].data, v8[k].odd, v8[k].par);
      end

      // Back-to-back: in_valid held, second word taken in the parity cycle.
      d0 = 8'h01;
      d1 = 8'hFF;
      b8.data_in  = d0;
      b8.odd_sel  = 1'b0;
      b8.in_valid = 1'b1;
      tick();
      for (int c = 1; c <= 18; c++) begin
         if (c <= 8)       eb = d0[c-1];
         else if (c == 9)  eb = 1'b1;
         else if (c <= 17) eb = d1[c-10];
         else              eb = 1'b0;
         chk("b2b ser_valid",   32'(b8.ser_valid),   32'd1);
         chk("b2b ser_out",     32'(b8.ser_out),     32'(eb));
         chk("b2b par_slot",    32'(b8.par_slot),    32'(c == 9 || c == 18));
         chk("b2b frame_start", 32'(b8.frame_start), 32'(c == 1 || c == 10));
         chk("b2b in_ready",    32'(b8.in_ready),    32'(c == 9 || c == 18));
         if (c == 9)  b8.data_in  = d1;
         if (c == 10) b8.in_valid = 1'b0;
         tick();
      end
      chk_idle8("b2b after");

      // Reset in data cycle 4 of 0x3C discards the frame.
      b8.data_in  = 8'h3C;
      b8.in_valid = 1'b1;
      tick();
      b8.in_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("midrst cycle4 bit",  32'(b8.ser_out),   32'd1);
      chk("midrst cycle4 busy", 32'(b8.busy),      32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle8("midrst asserted");
      #2;
      rst_n = 1'b1;
      #1;
      chk_idle8("midrst released");
      // First edge after release accepts a fresh word from its bit 0.
      send8(8'h96, 1'b0, 1'b0);

      // All 3-bit words in even mode on the WIDTH=3 instance.
      for (int k = 0; k < 8; k++) begin
         send3(v3[k].data, v3[k].par);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
